hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter LOAD_STALL_CYCLES, default 1, legal 1..4, meaning bubble cycles inserted per load-use hazard.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-004 The port list SHALL be, in this order:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- ex_valid  in  1  EX holds a real instruction (0 = nop/bubble).
- ex_is_load  in  1  EX instruction reads data memory into a register.
- ex_dst_addr  in  REG_ADDR_W  destination register of the EX instruction.
- id_rs_addr  in  REG_ADDR_W  rs field of the ID instruction.
- id_rt_addr  in  REG_ADDR_W  rt field of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt as a source (0 for I-type destinations).
- id_is_branch  in  1  ID instruction is a branch resolved in ID (used only under the macro in REQ-017).
- flush  in  1  pipeline redirect this cycle.
- stall  out  1  hold PC and IF/ID.
- idex_bubble  out  1  load a nop into ID/EX.
- stall_left  out  3  remaining stall cycles after the current one.

Function
REQ-005 hit_rs SHALL be id_uses_rs & (id_rs_addr == ex_dst_addr) & (ex_dst_addr != 0), and hit_rt SHALL be defined the same way using id_uses_rt and id_rt_addr.
REQ-006 A load-use hazard SHALL be ex_valid & ex_is_load & (hit_rs | hit_rt).
REQ-007 The FSM SHALL have two states: IDLE and HOLD.
REQ-008 In IDLE, when a hazard is present and flush=0, stall and idex_bubble SHALL assert combinationally in the same cycle.
- If LOAD_STALL_CYCLES > 1, the next state SHALL be HOLD with the counter loaded to LOAD_STALL_CYCLES-2.
- Otherwise the FSM SHALL stay in IDLE.
REQ-009 In HOLD, stall and idex_bubble SHALL be 1, stall_left SHALL equal the counter, and the counter SHALL decrement each cycle; at counter==0 the FSM SHALL return to IDLE.
REQ-010 In HOLD, hazard detection on the EX inputs SHALL be ignored, because EX holds the injected bubble.
REQ-011 Total consecutive stall cycles per hazard SHALL equal LOAD_STALL_CYCLES exactly.
REQ-012 flush=1 SHALL force stall=0 and idex_bubble=0 in that cycle and SHALL move the FSM to IDLE with the counter cleared, overriding both detection and HOLD.
REQ-013 Register 0 SHALL never cause a hazard.
REQ-014 A non-load EX writer SHALL never cause a stall; forwarding handles it.
REQ-015 Back-to-back hazards SHALL each produce a full stall sequence, with no merging and no skipped cycles.

Reset
REQ-016 Asserting reset SHALL immediately force state=IDLE, counter=0, stall=0, idex_bubble=0 and stall_left=0, regardless of the clock, including mid-HOLD; release SHALL resume detection on the first following rising edge.

Configuration
REQ-017 With HAZARD_BRANCH_CHECK_EN defined, the block SHALL additionally stall for exactly 1 cycle when all of the following hold:
- id_is_branch=1;
- ex_valid=1 and ex_is_load=0;
- hit_rs or hit_rt is true (an ALU result is needed by a branch in ID).
A load feeding a branch SHALL then stall LOAD_STALL_CYCLES+1 cycles.
REQ-018 With HAZARD_BRANCH_CHECK_EN undefined, id_is_branch SHALL be ignored and no branch-specific logic SHALL be generated.

Structure
REQ-019 A shared package SHALL hold:
- the FSM state enumeration (IDLE, HOLD);
- the constant ZERO_REG;
- the parameter-check constant MAX_LOAD_STALL=4.
REQ-020 Address comparison SHALL be a sub-module, hazard_addr_cmp, instantiated once per source operand and producing a hit bit.
REQ-021 An elaboration-time check SHALL reject LOAD_STALL_CYCLES outside 1..4.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Default parameters; EX lw to $5, ID add reading $5 as rs → stall=1 and idex_bubble=1 for exactly 1 cycle, then 0.
- LOAD_STALL_CYCLES=3; same hazard → stall high for 3 cycles with stall_left 2,1,0, then low.
- EX lw to $0, ID reads $0 → stall stays 0; EX lw to $7 with id_uses_rt=0 and id_rt_addr=7 → stall stays 0.
- LOAD_STALL_CYCLES=3; flush=1 in the 2nd stall cycle → stall=0 that cycle, state IDLE; async reset asserted mid-HOLD → outputs 0 before the next edge.
- Macro on: EX addu to $4, ID beq reading $4 → 1 stall cycle; macro off → 0 stall cycles.
- Two lw-use pairs back to back → two separate stall sequences of LOAD_STALL_CYCLES each.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the load-use hazard stall unit.
package hazard_stall_unit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int ZERO_REG       = 0;
    localparam int MAX_LOAD_STALL = 4;
    localparam int STALL_LEFT_W   = 3;

endpackage

// File: rtl/hazard_addr_cmp.sv
// Source-operand vs. EX-destination match; register 0 never matches.
module hazard_addr_cmp
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  uses,
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [REG_ADDR_W-1:0] dst_addr,
    output logic                  hit
);

    assign hit = uses & (src_addr == dst_addr) & (dst_addr != REG_ADDR_W'(ZERO_REG));

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector: stalls PC/IF-ID and bubbles ID/EX for LOAD_STALL_CYCLES.
// Optional macro HAZARD_BRANCH_CHECK_EN adds a 1-cycle stall for ALU results feeding an ID branch.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ex_valid,
    input  logic                    ex_is_load,
    input  logic [REG_ADDR_W-1:0]   ex_dst_addr,
    input  logic [REG_ADDR_W-1:0]   id_rs_addr,
    input  logic [REG_ADDR_W-1:0]   id_rt_addr,
    input  logic                    id_uses_rs,
    input  logic                    id_uses_rt,
    input  logic                    id_is_branch,
    input  logic                    flush,
    output logic                    stall,
    output logic                    idex_bubble,
    output logic [STALL_LEFT_W-1:0] stall_left
);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > MAX_LOAD_STALL) begin : g_bad_cfg
        $error("hazard_stall_unit: LOAD_STALL_CYCLES must be in 1..%0d", MAX_LOAD_STALL);
    end

    localparam logic [STALL_LEFT_W-1:0] LOAD_TOTAL = STALL_LEFT_W'(LOAD_STALL_CYCLES);

    state_t                  state, next_state;
    logic [STALL_LEFT_W-1:0] count, next_count;
    logic                    hit_rs, hit_rt;
    logic                    load_hazard;
    logic [STALL_LEFT_W-1:0] total_stall;
    logic                    stall_c, bubble_c;
    logic [STALL_LEFT_W-1:0] left_c;

    hazard_addr_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs (
        .uses     (id_uses_rs),
        .src_addr (id_rs_addr),
        .dst_addr (ex_dst_addr),
        .hit      (hit_rs)
    );

    hazard_addr_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rt (
        .uses     (id_uses_rt),
        .src_addr (id_rt_addr),
        .dst_addr (ex_dst_addr),
        .hit      (hit_rt)
    );

    assign load_hazard = ex_valid & ex_is_load & (hit_rs | hit_rt);

    // total_stall: full length of the stall sequence a hazard seen in IDLE starts
`ifdef HAZARD_BRANCH_CHECK_EN
    logic alu_branch_hazard;
    assign alu_branch_hazard = id_is_branch & ex_valid & ~ex_is_load & (hit_rs | hit_rt);
    assign total_stall = load_hazard       ? (LOAD_TOTAL + {{(STALL_LEFT_W-1){1'b0}}, id_is_branch}) :
                         alu_branch_hazard ? STALL_LEFT_W'(1) : '0;
`else
    logic unused_branch;
    assign unused_branch = id_is_branch;
    assign total_stall   = load_hazard ? LOAD_TOTAL : '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    always_comb begin
        next_state = state;
        next_count = count;
        stall_c    = 1'b0;
        bubble_c   = 1'b0;
        left_c     = '0;
        if (flush) begin
            next_state = IDLE;
            next_count = '0;
        end else if (state == HOLD) begin
            // EX holds our own bubble here, so detection is deliberately not consulted
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            left_c   = count;
            if (count == '0) begin
                next_state = IDLE;
            end else begin
                next_count = count - STALL_LEFT_W'(1);
            end
        end else if (total_stall != '0) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            left_c   = total_stall - STALL_LEFT_W'(1);
            if (total_stall > STALL_LEFT_W'(1)) begin
                next_state = HOLD;
                next_count = total_stall - STALL_LEFT_W'(2);
            end
        end
    end

    // Reset masks the combinational path so outputs drop without waiting for a clock
    assign stall       = stall_c & ~reset;
    assign idex_bubble = bubble_c & ~reset;
    assign stall_left  = reset ? '0 : left_c;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios plus random traffic against a stall-owed model.
module tb_hazard_stall_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       ex_valid, ex_is_load;
    logic [4:0] ex_dst_addr, id_rs_addr, id_rt_addr;
    logic       id_uses_rs, id_uses_rt, id_is_branch, flush;
    logic       stall1, bub1, stall3, bub3;
    logic [2:0] left1, left3;

`ifdef HAZARD_BRANCH_CHECK_EN
    localparam int BR_EN = 1;
`else
    localparam int BR_EN = 0;
`endif

    always #5 clock = ~clock;

    hazard_stall_unit dut1 (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_dst_addr(ex_dst_addr), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .flush(flush), .stall(stall1), .idex_bubble(bub1), .stall_left(left1)
    );

    hazard_stall_unit #(.LOAD_STALL_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_dst_addr(ex_dst_addr), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .flush(flush), .stall(stall3), .idex_bubble(bub3), .stall_left(left3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Number of stall cycles a hazard in the current inputs demands from an idle unit
    function automatic int stall_need(input int lsc);
        bit hrs, hrt;
        hrs = id_uses_rs && (id_rs_addr == ex_dst_addr) && (ex_dst_addr != 0);
        hrt = id_uses_rt && (id_rt_addr == ex_dst_addr) && (ex_dst_addr != 0);
        if (ex_valid && ex_is_load && (hrs || hrt))
            return lsc + ((BR_EN != 0 && id_is_branch) ? 1 : 0);
        if (BR_EN != 0 && ex_valid && id_is_branch && (hrs || hrt))
            return 1;
        return 0;
    endfunction

    // owed = stall cycles still to come after the ones already delivered
    int owed1 = 0, owed3 = 0, nxt1 = 0, nxt3 = 0;

    task automatic model_cmp(input string tag, input int lsc, input int owed, output int nxt,
                             input logic s, input logic b, input logic [2:0] l);
        int es, el, n;
        if (reset || flush) begin
            es = 0; el = 0; nxt = 0;
        end else if (owed > 0) begin
            es = 1; el = owed - 1; nxt = owed - 1;
        end else begin
            n   = stall_need(lsc);
            es  = (n > 0) ? 1 : 0;
            el  = (n > 0) ? n - 1 : 0;
            nxt = el;
        end
        check({tag, ".stall"}, s, es);
        check({tag, ".bubble"}, b, es);
        check({tag, ".left"}, l, el);
    endtask

    always @(negedge clock) begin
        model_cmp("model1", 1, owed1, nxt1, stall1, bub1, left1);
        model_cmp("model3", 3, owed3, nxt3, stall3, bub3, left3);
    end

    always @(posedge clock) begin
        owed1 <= reset ? 0 : nxt1;
        owed3 <= reset ? 0 : nxt3;
    end

    task automatic set_in(input int v, input int ld, input int dst, input int rs, input int rt,
                          input int urs, input int urt, input int br, input int fl);
        ex_valid     = 1'(v);
        ex_is_load   = 1'(ld);
        ex_dst_addr  = 5'(dst);
        id_rs_addr   = 5'(rs);
        id_rt_addr   = 5'(rt);
        id_uses_rs   = 1'(urs);
        id_uses_rt   = 1'(urt);
        id_is_branch = 1'(br);
        flush        = 1'(fl);
    endtask

    task automatic step(input int v, input int ld, input int dst, input int rs, input int rt,
                        input int urs, input int urt, input int br, input int fl);
        @(posedge clock);
        #1;
        set_in(v, ld, dst, rs, rt, urs, urt, br, fl);
    endtask

    task automatic step_hazard();
        step(1, 1, 5, 5, 6, 1, 1, 0, 0);
    endtask

    task automatic step_idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int pat_haz[7]   = '{1, 0, 0, 1, 0, 0, 0};
    int pat_s1[7]    = '{1, 0, 0, 1, 0, 0, 0};
    int pat_s3[7]    = '{1, 1, 1, 1, 1, 1, 0};
    int pat_l3[7]    = '{2, 1, 0, 2, 1, 0, 0};

    initial begin
        reset = 1'b1;
        set_in(1, 1, 5, 5, 6, 1, 1, 0, 0);
        #3;
        check("reset_stall1", stall1, 0);
        check("reset_stall3", stall3, 0);
        check("reset_left3", left3, 0);
        step_idle();
        @(negedge clock);
        #2 reset = 1'b0;

        // single load-use hazard, seen by both parameterisations
        step_hazard();
        #2;
        check("s1_stall1", stall1, 1);
        check("s1_bubble1", bub1, 1);
        check("s1_left1", left1, 0);
        check("s2_stall3_c0", stall3, 1);
        check("s2_left3_c0", left3, 2);
        step_idle();
        #2;
        check("s1_stall1_after", stall1, 0);
        check("s1_bubble1_after", bub1, 0);
        check("s2_stall3_c1", stall3, 1);
        check("s2_left3_c1", left3, 1);
        step_idle();
        #2;
        check("s2_stall3_c2", stall3, 1);
        check("s2_left3_c2", left3, 0);
        step_idle();
        #2;
        check("s2_stall3_end", stall3, 0);

        // register 0 and unused rt never stall
        step(1, 1, 0, 0, 0, 1, 1, 0, 0);
        #2;
        check("s3_zero_stall1", stall1, 0);
        check("s3_zero_stall3", stall3, 0);
        step(1, 1, 7, 3, 7, 1, 0, 0, 0);
        #2;
        check("s3_rt_unused_stall1", stall1, 0);
        check("s3_rt_unused_stall3", stall3, 0);
        step_idle();

        // flush in the second stall cycle
        step_hazard();
        #2;
        check("s4_stall3_c0", stall3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        check("s4_flush_stall3", stall3, 0);
        check("s4_flush_bubble3", bub3, 0);
        check("s4_flush_left3", left3, 0);
        step_idle();
        #2;
        check("s4_after_flush_stall3", stall3, 0);

        // asynchronous reset in the middle of HOLD
        step_hazard();
        #2;
        check("s4b_stall3_c0", stall3, 1);
        step_idle();
        #1;
        check("s4b_hold_stall3", stall3, 1);
        check("s4b_hold_left3", left3, 1);
        #1 reset = 1'b1;
        #1;
        check("s4b_async_stall3", stall3, 0);
        check("s4b_async_bubble3", bub3, 0);
        check("s4b_async_left3", left3, 0);
        @(negedge clock);
        #2 reset = 1'b0;
        step_idle();
        #2;
        check("s4b_after_reset_stall3", stall3, 0);

        // ALU result needed by a branch in ID
        step(1, 0, 4, 4, 9, 1, 1, 1, 0);
        #2;
        check("s5_branch_stall1", stall1, BR_EN);
        check("s5_branch_stall3", stall3, BR_EN);
        step_idle();
        #2;
        check("s5_branch_after1", stall1, 0);
        check("s5_branch_after3", stall3, 0);

        // back-to-back load-use pairs
        for (int i = 0; i < 7; i++) begin
            if (pat_haz[i] != 0) step_hazard();
            else step_idle();
            #2;
            check($sformatf("s6_stall1_%0d", i), stall1, pat_s1[i]);
            check($sformatf("s6_stall3_%0d", i), stall3, pat_s3[i]);
            check($sformatf("s6_left3_%0d", i), left3, pat_l3[i]);
        end

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0) ? 1 : 0);
        end

        step_idle();
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
